// File: rtl/lsu_bus_arbiter_if.sv
// Requester, completion and memory-side signals of the LSU bus arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface lsu_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_m0_req;
    logic          i_m0_wren;
    logic [AW-1:0] i_m0_addr;
    logic [DW-1:0] i_m0_wdata;
    logic [3:0]    i_m0_bmask;
    logic          o_m0_ack;
    logic [DW-1:0] o_m0_rdata;
    logic          o_m0_stall;

    logic          i_m1_req;
    logic          i_m1_wren;
    logic [AW-1:0] i_m1_addr;
    logic [DW-1:0] i_m1_wdata;
    logic [3:0]    i_m1_bmask;
    logic          o_m1_ack;
    logic [DW-1:0] o_m1_rdata;

    logic          o_mem_en;
    logic          o_mem_wren;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [3:0]    o_mem_bmask;
    logic [DW-1:0] i_mem_rdata;

    logic          o_gnt_id;
    logic          o_busy;

    modport slave (
        input  i_m0_req, i_m0_wren, i_m0_addr, i_m0_wdata, i_m0_bmask,
        output o_m0_ack, o_m0_rdata, o_m0_stall,
        input  i_m1_req, i_m1_wren, i_m1_addr, i_m1_wdata, i_m1_bmask,
        output o_m1_ack, o_m1_rdata,
        output o_mem_en, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask,
        input  i_mem_rdata,
        output o_gnt_id, o_busy
    );

    modport master (
        output i_m0_req, i_m0_wren, i_m0_addr, i_m0_wdata, i_m0_bmask,
        input  o_m0_ack, o_m0_rdata, o_m0_stall,
        output i_m1_req, i_m1_wren, i_m1_addr, i_m1_wdata, i_m1_bmask,
        input  o_m1_ack, o_m1_rdata,
        input  o_mem_en, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask,
        output i_mem_rdata,
        input  o_gnt_id, o_busy
    );
endinterface

// File: rtl/lsu_bus_arbiter.sv
// Shares one memory/IO bus between m0 (core LSU) and m1 (debug/loader), one transaction at a time.
// Latency: mem_en 1 cycle after grant, ack 2 (write) or 2+RD_LAT (read) cycles after grant.
// Backpressure: requests wait held high until ack; o_m0_stall freezes the core while m0 waits.
module lsu_bus_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1,
    parameter int RR_EN  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    lsu_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 1);

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          grant;
    logic          win_id;
    logic          last_gnt;
    logic          gnt_id;
    logic          lat_wren;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [3:0]    lat_bmask;
    logic [DW-1:0] rdata_q;
    logic          ack0, ack1;

    // On a tie, round-robin hands the bus to whoever did not own it last.
    always_comb begin
        grant  = (state == IDLE) && (bus.i_m0_req || bus.i_m1_req);
        win_id = 1'b0;
        if (bus.i_m0_req && bus.i_m1_req) begin
            win_id = (RR_EN != 0) ? ~last_gnt : 1'b0;
        end else if (bus.i_m1_req) begin
            win_id = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (grant) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (lat_wren) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt   = WAIT_LOAD;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // last_gnt resets to m1 so that m0 takes the first tie after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_gnt  <= 1'b1;
            gnt_id    <= 1'b0;
            lat_wren  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_bmask <= 4'd0;
            rdata_q   <= '0;
        end else begin
            if (grant) begin
                last_gnt  <= win_id;
                gnt_id    <= win_id;
                lat_wren  <= win_id ? bus.i_m1_wren  : bus.i_m0_wren;
                lat_addr  <= win_id ? bus.i_m1_addr  : bus.i_m0_addr;
                lat_wdata <= win_id ? bus.i_m1_wdata : bus.i_m0_wdata;
                lat_bmask <= win_id ? bus.i_m1_bmask : bus.i_m0_bmask;
            end
            if (state == WAIT && cnt == 4'd0) begin
                rdata_q <= bus.i_mem_rdata;
            end
        end
    end

    assign ack0 = (state == RESP) && !gnt_id;
    assign ack1 = (state == RESP) &&  gnt_id;

    assign bus.o_m0_ack   = ack0;
    assign bus.o_m1_ack   = ack1;
    assign bus.o_m0_rdata = (ack0 && !lat_wren) ? rdata_q : '0;
    assign bus.o_m1_rdata = (ack1 && !lat_wren) ? rdata_q : '0;
    assign bus.o_m0_stall = bus.i_m0_req & ~ack0;

    assign bus.o_mem_en    = (state == ISSUE);
    assign bus.o_mem_wren  = lat_wren;
    assign bus.o_mem_addr  = lat_addr;
    assign bus.o_mem_wdata = lat_wdata;
    assign bus.o_mem_bmask = lat_bmask;
    assign bus.o_gnt_id    = gnt_id;
    assign bus.o_busy      = (state != IDLE);
endmodule
